// File: rtl/abrutech_bus_pkg.sv
// Shared definitions for the bus arbiter: FSM state encoding and a width helper.
package abrutech_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_OWNED   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping around; ptr itself is checked last.
module arb_rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the farthest slot to the nearest so the nearest requester wins.
  always_comb begin
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
    end
  end

  assign any    = |req;
  assign onehot = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with guard gap and slave-busy hold-off.
// Optional ownership timeout with per-master mask: define ARB_TIMEOUT_EN.
module bus_arbiter
  import abrutech_bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int GAP_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IW            = clog2_min1(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] mreq,
  input  logic                   slave_busy,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IW-1:0]          grant_id,
  output logic                   bus_util,
  output logic                   timeout_err
);

  localparam int GW = clog2_min1(GAP_CYCLES + 1);

  if (NUM_MASTERS < 2 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("bus_arbiter: illegal parameter set");
  end

  arb_state_t             state, state_nxt;
  logic [NUM_MASTERS-1:0] grant_nxt;
  logic [IW-1:0]          id_nxt, rr_ptr, ptr_nxt;
  // gap_cnt counts RELEASE cycles including the current one (saturating).
  logic [GW-1:0]          gap_cnt, gap_nxt;

  logic [NUM_MASTERS-1:0] pick_req, pick_onehot;
  logic [IW-1:0]          pick_idx;
  logic                   pick_any;

`ifdef ARB_TIMEOUT_EN
  localparam int OW = clog2_min1(TIMEOUT_CYCLES);
  logic [OW-1:0]          own_cnt, own_nxt;
  logic [NUM_MASTERS-1:0] mask, mask_nxt;
  logic                   to_q, to_nxt;

  assign pick_req    = mreq & ~mask;
  assign timeout_err = to_q;

  // Timeout bookkeeping: ownership counter, skip mask, error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_cnt <= '0;
      mask    <= '0;
      to_q    <= 1'b0;
    end else begin
      own_cnt <= own_nxt;
      mask    <= mask_nxt;
      to_q    <= to_nxt;
    end
  end
`else
  assign pick_req    = mreq;
  assign timeout_err = 1'b0;
`endif

  arb_rr_picker #(.N(NUM_MASTERS), .IW(IW)) u_picker (
    .req    (pick_req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign bus_util = |grant;

  // State and output registers; reset puts the pointer on the last master so 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_IDLE;
      grant    <= '0;
      grant_id <= '0;
      rr_ptr   <= IW'(NUM_MASTERS - 1);
      gap_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      grant_id <= id_nxt;
      rr_ptr   <= ptr_nxt;
      gap_cnt  <= gap_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    id_nxt    = grant_id;
    ptr_nxt   = rr_ptr;
    gap_nxt   = gap_cnt;
`ifdef ARB_TIMEOUT_EN
    own_nxt   = own_cnt;
    mask_nxt  = mask & mreq;   // a master seen low regains eligibility
    to_nxt    = 1'b0;
`endif
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          state_nxt = ARB_OWNED;
          grant_nxt = pick_onehot;
          id_nxt    = pick_idx;
          ptr_nxt   = pick_idx;
`ifdef ARB_TIMEOUT_EN
          own_nxt   = '0;
`endif
        end
      end
      ARB_OWNED: begin
        if (!mreq[grant_id]) begin
          state_nxt = ARB_RELEASE;
          grant_nxt = '0;
          gap_nxt   = GW'(1);
        end
`ifdef ARB_TIMEOUT_EN
        else if (own_cnt == OW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt          = ARB_RELEASE;
          grant_nxt          = '0;
          gap_nxt            = GW'(1);
          to_nxt             = 1'b1;
          mask_nxt[grant_id] = 1'b1;
        end else begin
          own_nxt = own_cnt + OW'(1);
        end
`endif
      end
      ARB_RELEASE: begin
        if (gap_cnt == GW'(GAP_CYCLES) && !slave_busy) begin
          state_nxt = ARB_IDLE;
          gap_nxt   = '0;
        end else if (gap_cnt != GW'(GAP_CYCLES)) begin
          gap_nxt = gap_cnt + GW'(1);
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic
// compared every cycle against a behavioural model.
module tb_bus_arbiter;

  localparam int N    = 4;
  localparam int GAP  = 1;
  localparam int TOUT = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk, rst;
  logic [N-1:0] mreq;
  logic         slave_busy;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic         bus_util, timeout_err;

  int n_chk, n_fail;

  // model: owner (-1 none), release age (-1 when not releasing)
  int       m_owner, m_ptr, m_id, m_rel, m_held;
  bit       m_to;
  bit [N-1:0] m_blk;

  bus_arbiter #(.NUM_MASTERS(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .mreq        (mreq),
    .slave_busy  (slave_busy),
    .grant       (grant),
    .grant_id    (grant_id),
    .bus_util    (bus_util),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  always @(negedge clk)
    if (!rst) a_util: assert (bus_util == |grant)
      else $error("FAIL util_assert bus_util=%0b grant=%b", bus_util, grant);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = N - 1; m_id = 0; m_rel = -1; m_held = 0; m_to = 0; m_blk = '0;
  endtask

  // One clock edge of the arbitration rules, using the inputs held across the edge.
  task automatic model_edge();
    int w, blk_set;
    w = -1; blk_set = -1; m_to = 0;
    if (m_owner >= 0) begin
      if (!mreq[m_owner]) begin
        m_owner = -1; m_rel = 0;
      end else if (TO_EN && m_held == TOUT - 1) begin
        blk_set = m_owner; m_owner = -1; m_rel = 0; m_to = 1;
      end else m_held++;
    end else if (m_rel >= 0) begin
      m_rel++;
      if (m_rel >= GAP && !slave_busy) m_rel = -1;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (mreq[c] && !(TO_EN && m_blk[c])) begin w = c; break; end
      end
      if (w >= 0) begin m_owner = w; m_ptr = w; m_id = w; m_held = 0; end
    end
    for (int i = 0; i < N; i++) if (!mreq[i]) m_blk[i] = 0;
    if (blk_set >= 0) m_blk[blk_set] = 1;
  endtask

  task automatic compare();
    logic [N-1:0] eg;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    chk("grant", 32'(grant), 32'(eg));
    chk("grant_id", 32'(grant_id), 32'(m_id));
    chk("bus_util", 32'(bus_util), 32'(m_owner >= 0));
    chk("timeout_err", 32'(timeout_err), 32'(m_to));
    chk("onehot", 32'($countones(grant) <= 1), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1; mreq = '0; slave_busy = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_id", 32'(grant_id), 32'd0);
    chk("rst_util", 32'(bus_util), 32'd0);
    chk("rst_to", 32'(timeout_err), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int n, own_cyc, pulses;
    logic [N-1:0] prev;
    int order[$];
    n_chk = 0; n_fail = 0;

    // 1: async reset in the middle of a grant
    do_reset();
    mreq = 4'b0010;
    step();
    chk("t1_pre", 32'(grant), 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("t1_grant", 32'(grant), 32'd0);
    chk("t1_util", 32'(bus_util), 32'd0);
    chk("t1_id", 32'(grant_id), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0; mreq = '0;
    repeat (3) step();

    // 2: single request, release, earliest re-grant
    do_reset();
    mreq = 4'b0100;
    step();
    chk("t2_grant", 32'(grant), 32'h4);
    chk("t2_id", 32'(grant_id), 32'd2);
    repeat (9) step();
    mreq = '0;
    step();
    chk("t2_drop", 32'(grant), 32'd0);
    mreq = 4'b0100;
    step();
    chk("t2_gap", 32'(grant), 32'd0);
    step();
    chk("t2_regrant", 32'(grant), 32'h4);

    // 3: round-robin order with every master requesting
    do_reset();
    mreq = 4'b1111; own_cyc = 0; prev = '0;
    for (int c = 0; c < 80 && order.size() < 6; c++) begin
      step();
      if (grant != 0 && prev == 0) order.push_back(int'(grant_id));
      prev = grant;
      own_cyc = (grant != 0) ? own_cyc + 1 : 0;
      mreq = (own_cyc == 5) ? (4'b1111 & ~grant) : 4'b1111;
    end
    chk("t3_count", 32'(order.size()), 32'd6);
    for (int i = 0; i < order.size(); i++) chk("t3_order", 32'(order[i]), 32'(i % N));

    // 4: slave busy holds off the next grant
    do_reset();
    mreq = 4'b0010;
    repeat (3) step();
    mreq = 4'b1000; slave_busy = 1'b1;
    repeat (20) step();
    chk("t4_hold", 32'(grant), 32'd0);
    slave_busy = 1'b0;
    n = 0;
    while (grant != 4'b1000 && n < 10) begin step(); n++; end
    chk("t4_lat", 32'(n), 32'd2);

    // 5: owner drops on the same edge another master raises
    do_reset();
    mreq = 4'b0001;
    repeat (3) step();
    mreq = 4'b0100;
    step();
    chk("t5_rel", 32'(grant), 32'd0);
    step();
    chk("t5_gap", 32'(grant), 32'd0);
    step();
    chk("t5_next", 32'(grant), 32'h4);

    // 6: long ownership by master 0 with master 1 waiting
    do_reset();
    mreq = 4'b0011;
    step();
    chk("t6_first", 32'(grant), 32'h1);
    pulses = 0;
    repeat (16) begin step(); pulses += int'(timeout_err); end
`ifdef ARB_TIMEOUT_EN
    chk("t6_drop", 32'(grant), 32'd0);
    step(); pulses += int'(timeout_err);
    chk("t6_pulses", 32'(pulses), 32'd1);
    step();
    chk("t6_next", 32'(grant), 32'h2);
    mreq = 4'b0001;
    repeat (6) step();
    chk("t6_masked", 32'(grant), 32'd0);
    mreq = 4'b0000; step();
    mreq = 4'b0001;
    repeat (2) step();
    chk("t6_unmask", 32'(grant), 32'h1);
`else
    repeat (24) begin step(); pulses += int'(timeout_err); end
    chk("t6_keep", 32'(grant), 32'h1);
    chk("t6_pulses", 32'(pulses), 32'd0);
`endif

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) mreq[i] = ~mreq[i];
      if ($urandom_range(5) == 0) slave_busy = ~slave_busy;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
